// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage feeding the RV32 decoder.
// Keeps the fetch PC, issues one word read at a time to instruction memory,
// buffers returned words in a small FIFO and hands them to the decoder as
// instruction/pc_out qualified by a single-cycle id_en pulse. A redirect
// flushes everything fetched so far and restarts fetch at the new target.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        id_en
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Fetch sequencer states: REQ may issue, WAIT holds a live read,
  // DROP holds a read whose data must be thrown away.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // Force the two low bits of a fetch target to zero.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Next sequential word address; wraps naturally at the top of memory.
  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

  state_t            state_r;
  logic [31:0]       fetch_pc_r;
  logic [31:0]       wait_pc_r;

  logic [31:0]       fifo_pc_r   [FIFO_DEPTH];
  logic [31:0]       fifo_data_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;

  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              req_s;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;

  assign fifo_full_s  = (count_r == DEPTH_C);
  assign fifo_empty_s = (count_r == {CNT_W{1'b0}});

  // A request is withdrawn in a redirect cycle so the old stream never gets
  // a new beat accepted; reset also holds it low.
  assign req_s    = !reset && (state_r == ST_REQ) && !fifo_full_s && !redirect_valid;
  assign accept_s = req_s && imem_ready;

  // Returned data is kept only in WAIT and only if no flush happens now.
  assign push_s   = !reset && (state_r == ST_WAIT) && imem_rvalid && !redirect_valid;
  assign pop_s    = !reset && !fifo_empty_s && !stall && !redirect_valid;

  assign imem_req  = req_s;
  assign imem_addr = fetch_pc_r;

  // Fetch sequencer: tracks the outstanding read and advances the fetch PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_REQ;
      fetch_pc_r <= RESET_PC;
      wait_pc_r  <= RESET_PC;
    end else begin
      case (state_r)
        ST_REQ: begin
          if (redirect_valid) begin
            fetch_pc_r <= word_align(redirect_pc);
          end else if (accept_s) begin
            wait_pc_r  <= fetch_pc_r;
            fetch_pc_r <= next_word(fetch_pc_r);
            state_r    <= ST_WAIT;
          end else begin
            state_r    <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (redirect_valid) begin
            fetch_pc_r <= word_align(redirect_pc);
            // The in-flight read still owes a response unless it lands now.
            state_r    <= imem_rvalid ? ST_REQ : ST_DROP;
          end else if (imem_rvalid) begin
            state_r    <= ST_REQ;
          end else begin
            state_r    <= ST_WAIT;
          end
        end
        ST_DROP: begin
          if (redirect_valid) begin
            fetch_pc_r <= word_align(redirect_pc);
          end else begin
            fetch_pc_r <= fetch_pc_r;
          end
          if (imem_rvalid) begin
            state_r <= ST_REQ;
          end else begin
            state_r <= ST_DROP;
          end
        end
        default: begin
          state_r <= ST_REQ;
        end
      endcase
    end
  end

  // FIFO bookkeeping: pointers and occupancy, cleared by a redirect flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (redirect_valid) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage: each entry keeps the word together with its fetch address.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_pc_r[wr_ptr_r]   <= wait_pc_r;
      fifo_data_r[wr_ptr_r] <= imem_rdata;
    end
  end

  // Decoder-facing output register: one id_en pulse per popped word.
  always_ff @(posedge clk) begin
    if (reset) begin
      instruction <= 32'h0000_0000;
      pc_out      <= 32'h0000_0000;
      id_en       <= 1'b0;
    end else if (pop_s) begin
      instruction <= fifo_data_r[rd_ptr_r];
      pc_out      <= fifo_pc_r[rd_ptr_r];
      id_en       <= 1'b1;
    end else begin
      id_en       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a memory responder, a program-order
// reference model feeding a scoreboard queue, and an independent output monitor.
module tb_instr_fetch_unit;

  localparam logic [31:0] KEY      = 32'hA5A5_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] HI_PC    = 32'hFFFF_FFF8;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        id_en;

  logic        hi_stall;
  logic        hi_redirect_valid;
  logic [31:0] hi_redirect_pc;
  logic        hi_req;
  logic [31:0] hi_addr;
  logic        hi_ready;
  logic        hi_rvalid;
  logic [31:0] hi_rdata;
  logic [31:0] hi_instruction;
  logic [31:0] hi_pc_out;
  logic        hi_id_en;

  int checks = 0;
  int errors = 0;
  int n_id   = 0;

  // scoreboard: {pc, instruction} in program order
  logic [63:0] exp_q [$];
  logic [31:0] model_pc;
  bit          prev_redir;

  // memory responder controls
  int          lat_mode   = 0;   // 0: zero-wait, 1: fixed 2 extra, 2: random
  bit          rand_ready = 1'b0;
  bit          hold_low   = 1'b0;
  bit          mem_busy;
  int          mem_wait;
  logic [31:0] mem_addr;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) u_dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc_out(pc_out), .id_en(id_en)
  );

  instr_fetch_unit #(.RESET_PC(HI_PC), .FIFO_DEPTH(2)) u_dut_hi (
    .clk(clk), .reset(reset), .stall(hi_stall),
    .redirect_valid(hi_redirect_valid), .redirect_pc(hi_redirect_pc),
    .imem_req(hi_req), .imem_addr(hi_addr), .imem_ready(hi_ready),
    .imem_rvalid(hi_rvalid), .imem_rdata(hi_rdata),
    .instruction(hi_instruction), .pc_out(hi_pc_out), .id_en(hi_id_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_accept(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = imem_req && imem_ready;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for accepted request", name);
    end
  endtask

  task automatic wait_id(input string name, input logic [31:0] exp_pc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = id_en;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for id_en", name);
    end else begin
      check32(name, pc_out, exp_pc);
    end
  endtask

  task automatic reset_checks(input string tag);
    check32({tag, "_imem_req"}, {31'd0, imem_req}, 32'd0);
    check32({tag, "_imem_addr"}, imem_addr, RESET_PC);
    check32({tag, "_instruction"}, instruction, 32'd0);
    check32({tag, "_pc_out"}, pc_out, 32'd0);
    check32({tag, "_id_en"}, {31'd0, id_en}, 32'd0);
  endtask

  // Memory responder: one outstanding read, data = address ^ KEY.
  initial begin
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    mem_busy    = 1'b0;
    mem_wait    = 0;
    mem_addr    = 32'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_busy = 1'b0;
      end else if (imem_req && imem_ready) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_wait = (lat_mode == 0) ? 0 : (lat_mode == 1) ? 2 : int'($urandom_range(0, 2));
      end
      @(posedge clk);
      #1;
      if (mem_busy && mem_wait == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_addr ^ KEY;
        mem_busy    = 1'b0;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (mem_busy) mem_wait--;
      end
      imem_ready = hold_low ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Reference model: program order of fetched words, flushed on redirect/reset.
  initial begin
    logic        s_reset, s_redir, s_acc, s_req, s_id;
    logic [31:0] s_rpc, s_addr;
    model_pc   = RESET_PC;
    prev_redir = 1'b0;
    forever begin
      @(negedge clk);
      s_reset = reset;
      s_redir = redirect_valid;
      s_rpc   = redirect_pc;
      s_req   = imem_req;
      s_acc   = imem_req && imem_ready;
      s_addr  = imem_addr;
      s_id    = id_en;
      #1;
      if (s_reset) begin
        exp_q.delete();
        model_pc   = RESET_PC;
        prev_redir = 1'b0;
      end else begin
        if (prev_redir) check32("id_en_after_redirect", {31'd0, s_id}, 32'd0);
        prev_redir = s_redir;
        if (s_redir) begin
          check32("req_in_redirect_cycle", {31'd0, s_req}, 32'd0);
          exp_q.delete();
          model_pc = {s_rpc[31:2], 2'b00};
        end else if (s_acc) begin
          check32("fetch_addr", s_addr, model_pc);
          exp_q.push_back({model_pc, model_pc ^ KEY});
          model_pc = model_pc + 32'd4;
        end
      end
    end
  end

  // Monitor: every presented instruction must be the next expected one.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!reset && id_en) begin
        n_id++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_id_en pc_out=%h expected=none", pc_out);
        end else begin
          e = exp_q.pop_front();
          check32("pc_out", pc_out, e[63:32]);
          check32("instruction", instruction, e[31:0]);
        end
      end
    end
  end

  // High-address instance: zero-wait memory, first three addresses must wrap.
  initial begin
    int          hi_n;
    bit          hi_acc;
    logic [31:0] hi_la;
    hi_stall          = 1'b0;
    hi_redirect_valid = 1'b0;
    hi_redirect_pc    = 32'd0;
    hi_ready          = 1'b1;
    hi_rvalid         = 1'b0;
    hi_rdata          = 32'd0;
    hi_n              = 0;
    hi_la             = 32'd0;
    forever begin
      @(negedge clk);
      if (reset) hi_n = 0;
      hi_acc = !reset && hi_req;
      if (hi_acc) hi_la = hi_addr;
      if (hi_acc && hi_n < 3) begin
        check32($sformatf("hi_addr%0d", hi_n), hi_addr, HI_PC + 32'(4 * hi_n));
        hi_n++;
      end
      @(posedge clk);
      #1;
      hi_rvalid = hi_acc;
      hi_rdata  = hi_la ^ KEY;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    int n0;
    logic [31:0] a0;
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks("reset");

    // latency from reset release: first id_en in cycle 3
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check32($sformatf("id_en_cycle%0d", c), {31'd0, id_en}, (c == 3) ? 32'd1 : 32'd0);
    end
    tick();
    n0 = n_id;
    repeat (20) @(posedge clk);
    #2;
    check32("throughput_20cyc", 32'(n_id - n0), 32'd10);

    // stall for 6 cycles: buffer fills and requests stop
    stall = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check32("req_when_full", {31'd0, imem_req}, 32'd0);
    tick();
    stall = 1'b0;
    repeat (16) tick();

    // redirect while a read is outstanding
    lat_mode = 1;
    wait_accept("redir_wait_acc");
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    wait_accept("redir_wait_new");
    check32("redir_wait_addr", imem_addr, 32'h0000_0100);
    wait_id("redir_wait_first_pc", 32'h0000_0100);
    repeat (6) tick();

    // redirect in the same cycle as the returning data
    lat_mode = 0;
    wait_accept("redir_rv_acc");
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check32("redir_rv_req", {31'd0, imem_req}, 32'd1);
    check32("redir_rv_addr", imem_addr, 32'h0000_0200);
    wait_id("redir_rv_first_pc", 32'h0000_0200);
    repeat (6) tick();

    // memory not ready for 4 cycles: address must hold
    hold_low = 1'b1;
    tick();
    tick();
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        seen = imem_req;
      end
      a0 = imem_addr;
      for (int i = 0; i < 4; i++) begin
        if (i > 0) @(negedge clk);
        check32($sformatf("hold_req%0d", i), {31'd0, imem_req}, 32'd1);
        check32($sformatf("hold_addr%0d", i), imem_addr, a0);
      end
    end
    tick();
    hold_low = 1'b0;
    repeat (8) tick();

    // reset while waiting for a response
    lat_mode = 1;
    wait_accept("rst_wait_acc");
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    reset_checks("midreset");
    tick();
    reset    = 1'b0;
    lat_mode = 0;
    wait_accept("rst_first_acc");
    check32("rst_first_addr", imem_addr, RESET_PC);
    repeat (10) tick();

    // randomized traffic
    lat_mode   = 2;
    rand_ready = 1'b1;
    for (int i = 0; i < 800; i++) begin
      tick();
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
    end
    tick();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    rand_ready     = 1'b0;
    repeat (30) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
